// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC width and fetch FSM encoding.
// Used by the fetch unit and its next-PC selector.
package cpu_pkg;

    localparam int PC_W = 16;

    localparam logic [PC_W-1:0] PC_ONE = 1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALTED   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_npc_sel.sv
// Combinational next-PC selection for the fetch unit.
// Priority: redirect > hold (stall/halted) > BTB > sequential.
module npc_sel
    import cpu_pkg::*;
(
    input  logic            run,
    input  logic            halted,
    input  logic            stall,
    input  logic            BTB_taken,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] IF_br_target,
    input  logic            EX_is_branch,
    input  logic            EX_branch_taken,
    input  logic            EX_pred_taken,
    input  logic [PC_W-1:0] EX_branch_target,
    input  logic [PC_W-1:0] EX_pc_plus_one,
    output logic [PC_W-1:0] pc_plus_one,
    output logic            mispredict,
    output logic [PC_W-1:0] npc
);

    logic redir;
    logic hold;

    assign pc_plus_one = pc + PC_ONE;
    assign mispredict  = EX_is_branch & (EX_branch_taken != EX_pred_taken);

    // Redirect only acts in RUN; hold can never overlap it.
    assign redir = run & mispredict;
    assign hold  = halted | (stall & ~redir);

    always_comb begin
        npc = pc_plus_one;
        unique case (1'b1)
            redir:   npc = EX_branch_taken ? EX_branch_target
                                           : EX_pc_plus_one;
            hold:    npc = pc;
            default: npc = BTB_taken ? IF_br_target : pc_plus_one;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register, IF/ID register and RUN/REDIRECT/HALTED FSM.
// Define FETCH_BR_STATS_EN to add br_cnt/mispred_cnt counters.
module fetch_pc_unit
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            halt,
    input  logic            BTB_taken,
    input  logic [PC_W-1:0] IF_br_target,
    input  logic            EX_is_branch,
    input  logic            EX_branch_taken,
    input  logic            EX_pred_taken,
    input  logic [PC_W-1:0] EX_branch_target,
    input  logic [PC_W-1:0] EX_pc_plus_one,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] IF_pc_plus_one,
    output logic [PC_W-1:0] ID_pc_plus_one,
    output logic            ID_pred_taken,
    output logic            ID_valid,
    output logic            flush
`ifdef FETCH_BR_STATS_EN
    ,
    output logic [15:0]     br_cnt,
    output logic [15:0]     mispred_cnt
`endif
);

    fetch_state_t    state;
    logic            run;
    logic            halted;
    logic            mispredict;
    logic [PC_W-1:0] npc;

    assign run    = (state == ST_RUN);
    assign halted = (state == ST_HALTED);
    assign flush  = run & mispredict & rst_n;

    npc_sel u_npc_sel (
        .run              (run),
        .halted           (halted),
        .stall            (stall),
        .BTB_taken        (BTB_taken),
        .pc               (pc),
        .IF_br_target     (IF_br_target),
        .EX_is_branch     (EX_is_branch),
        .EX_branch_taken  (EX_branch_taken),
        .EX_pred_taken    (EX_pred_taken),
        .EX_branch_target (EX_branch_target),
        .EX_pc_plus_one   (EX_pc_plus_one),
        .pc_plus_one      (IF_pc_plus_one),
        .mispredict       (mispredict),
        .npc              (npc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= '0;
            ID_pc_plus_one <= '0;
            ID_pred_taken  <= 1'b0;
            ID_valid       <= 1'b0;
            state          <= ST_RUN;
        end else begin
            pc <= npc;
            case (state)
                ST_RUN: begin
                    if (mispredict) begin
                        ID_valid <= 1'b0;
                        state    <= ST_REDIRECT;
                    end else if (!stall) begin
                        ID_pc_plus_one <= IF_pc_plus_one;
                        ID_pred_taken  <= BTB_taken;
                        // A decoded halt retires the fetch stream here.
                        ID_valid       <= ~(halt & ID_valid);
                        if (halt && ID_valid)
                            state <= ST_HALTED;
                    end
                end
                ST_REDIRECT: begin
                    if (!stall) begin
                        ID_pc_plus_one <= IF_pc_plus_one;
                        ID_pred_taken  <= BTB_taken;
                    end
                    ID_valid <= 1'b0;
                    state    <= ST_RUN;
                end
                ST_HALTED: begin
                    ID_valid <= 1'b0;
                end
                default: begin
                    ID_valid <= 1'b0;
                    state    <= ST_RUN;
                end
            endcase
        end
    end

`ifdef FETCH_BR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else begin
            if (run && EX_is_branch && br_cnt != 16'hFFFF)
                br_cnt <= br_cnt + 16'd1;
            if (flush && mispred_cnt != 16'hFFFF)
                mispred_cnt <= mispred_cnt + 16'd1;
        end
    end
`endif

endmodule
